// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, immediate formats and the ID/EX payload.
package rv32_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic              funct7b5;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
    } idex_t;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] opcode);
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: return IMM_I;
            OP_STORE:                 return IMM_S;
            OP_BRANCH:                return IMM_B;
            OP_LUI, OP_AUIPC:         return IMM_U;
            OP_JAL:                   return IMM_J;
            default:                  return IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: IF/ID inputs, register file port, writeback bypass and ID/EX outputs.
interface decode_stage_if;
    import rv32_pkg::*;

    logic [31:0]       IF_INSTR;
    logic [XLEN-1:0]   IF_PC;
    logic              IF_VALID;
    logic              FLUSH;
    logic [REG_AW-1:0] RF_OUT1ADDR;
    logic [REG_AW-1:0] RF_OUT2ADDR;
    logic [XLEN-1:0]   RF_OUT1;
    logic [XLEN-1:0]   RF_OUT2;
    logic              WB_WRITE;
    logic [REG_AW-1:0] WB_ADDR;
    logic [XLEN-1:0]   WB_DATA;
    logic              STALL;
    logic              EX_VALID;
    logic [XLEN-1:0]   EX_PC;
    logic [XLEN-1:0]   EX_RS1DATA;
    logic [XLEN-1:0]   EX_RS2DATA;
    logic [XLEN-1:0]   EX_IMM;
    logic [REG_AW-1:0] EX_RS1;
    logic [REG_AW-1:0] EX_RS2;
    logic [REG_AW-1:0] EX_RD;
    logic [6:0]        EX_OPCODE;
    logic [2:0]        EX_FUNCT3;
    logic              EX_FUNCT7B5;
    logic              EX_REGWRITE;
    logic              EX_MEMREAD;
    logic              EX_MEMWRITE;

    modport master (
        output IF_INSTR, IF_PC, IF_VALID, FLUSH, RF_OUT1, RF_OUT2,
               WB_WRITE, WB_ADDR, WB_DATA,
        input  RF_OUT1ADDR, RF_OUT2ADDR, STALL, EX_VALID, EX_PC, EX_RS1DATA,
               EX_RS2DATA, EX_IMM, EX_RS1, EX_RS2, EX_RD, EX_OPCODE, EX_FUNCT3,
               EX_FUNCT7B5, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE
    );

    modport slave (
        input  IF_INSTR, IF_PC, IF_VALID, FLUSH, RF_OUT1, RF_OUT2,
               WB_WRITE, WB_ADDR, WB_DATA,
        output RF_OUT1ADDR, RF_OUT2ADDR, STALL, EX_VALID, EX_PC, EX_RS1DATA,
               EX_RS2DATA, EX_IMM, EX_RS1, EX_RS2, EX_RD, EX_OPCODE, EX_FUNCT3,
               EX_FUNCT7B5, EX_REGWRITE, EX_MEMREAD, EX_MEMWRITE
    );

endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; R-type and unknown opcodes yield zero.
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm_c
);

    always_comb begin
        imm_c = '0;
        case (imm_fmt(instr[6:0]))
            IMM_I:   imm_c = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm_c = {instr[31:12], 12'b0};
            IMM_J:   imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm_c = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: operand fetch with writeback bypass, immediates, load-use stall, ID/EX register.
module decode_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic           CLK,
    input logic           RESET,
    decode_stage_if.slave bus
);

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   imm_c;
    logic              rs1_used_c;
    logic              rs2_used_c;
    logic              writes_rd_c;
    logic              live_c;
    logic              hazard_c;
    logic              stall_c;
    idex_t             idex_d;
    idex_t             idex_q;

    assign opcode = bus.IF_INSTR[6:0];
    assign rd     = bus.IF_INSTR[11:7];
    assign rs1    = bus.IF_INSTR[19:15];
    assign rs2    = bus.IF_INSTR[24:20];

    assign bus.RF_OUT1ADDR = rs1;
    assign bus.RF_OUT2ADDR = rs2;

    imm_gen u_imm_gen (
        .instr (bus.IF_INSTR),
        .imm_c (imm_c)
    );

    // x0 reads as zero, then a write landing this edge overrides the stale file data.
    function automatic logic [XLEN-1:0] pick_operand(
        input logic [REG_AW-1:0] addr,
        input logic [XLEN-1:0]   rf_data,
        input logic              wb_write,
        input logic [REG_AW-1:0] wb_addr,
        input logic [XLEN-1:0]   wb_data
    );
        if (addr == REG_AW'(0))                 return '0;
        else if (wb_write && (wb_addr == addr)) return wb_data;
        else                                    return rf_data;
    endfunction

    always_comb begin
        rs1_used_c  = 1'b0;
        rs2_used_c  = 1'b0;
        writes_rd_c = 1'b0;
        case (opcode)
            OP_R: begin
                rs1_used_c  = 1'b1;
                rs2_used_c  = 1'b1;
                writes_rd_c = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                rs1_used_c  = 1'b1;
                writes_rd_c = 1'b1;
            end
            OP_STORE, OP_BRANCH: begin
                rs1_used_c  = 1'b1;
                rs2_used_c  = 1'b1;
            end
            OP_LUI, OP_AUIPC, OP_JAL: writes_rd_c = 1'b1;
            default: ;
        endcase
    end

    // Load in EX whose destination is a source this instruction actually reads.
    assign hazard_c = idex_q.valid && idex_q.memread && (idex_q.rd != REG_AW'(0)) && bus.IF_VALID &&
                      ((rs1_used_c && (rs1 == idex_q.rd)) || (rs2_used_c && (rs2 == idex_q.rd)));
    assign stall_c  = hazard_c && !bus.FLUSH;
    assign bus.STALL = stall_c;

    assign live_c = bus.IF_VALID && (bus.IF_INSTR != NOP_INSTR);

    always_comb begin
        idex_d = '0;
        if (!bus.FLUSH && !stall_c) begin
            idex_d.valid    = bus.IF_VALID;
            idex_d.pc       = bus.IF_PC;
            idex_d.rs1_data = pick_operand(rs1, bus.RF_OUT1, bus.WB_WRITE, bus.WB_ADDR, bus.WB_DATA);
            idex_d.rs2_data = pick_operand(rs2, bus.RF_OUT2, bus.WB_WRITE, bus.WB_ADDR, bus.WB_DATA);
            idex_d.imm      = imm_c;
            idex_d.rs1      = rs1;
            idex_d.rs2      = rs2;
            idex_d.rd       = rd;
            idex_d.opcode   = opcode;
            idex_d.funct3   = bus.IF_INSTR[14:12];
            idex_d.funct7b5 = bus.IF_INSTR[30];
            idex_d.regwrite = live_c && writes_rd_c && (rd != REG_AW'(0));
            idex_d.memread  = live_c && (opcode == OP_LOAD);
            idex_d.memwrite = live_c && (opcode == OP_STORE);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    assign bus.EX_VALID    = idex_q.valid;
    assign bus.EX_PC       = idex_q.pc;
    assign bus.EX_RS1DATA  = idex_q.rs1_data;
    assign bus.EX_RS2DATA  = idex_q.rs2_data;
    assign bus.EX_IMM      = idex_q.imm;
    assign bus.EX_RS1      = idex_q.rs1;
    assign bus.EX_RS2      = idex_q.rs2;
    assign bus.EX_RD       = idex_q.rd;
    assign bus.EX_OPCODE   = idex_q.opcode;
    assign bus.EX_FUNCT3   = idex_q.funct3;
    assign bus.EX_FUNCT7B5 = idex_q.funct7b5;
    assign bus.EX_REGWRITE = idex_q.regwrite;
    assign bus.EX_MEMREAD  = idex_q.memread;
    assign bus.EX_MEMWRITE = idex_q.memwrite;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: driver queues hand-computed ID/EX contents, monitor compares.
module tb_decode_stage;
    import rv32_pkg::*;

    logic CLK;
    logic RESET;
    int   tests;
    int   errors;

    idex_t exp_q[$];
    bit    ctl_q[$];
    string name_q[$];

    decode_stage_if bus ();

    decode_stage dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic idex_t mk(input logic v, input logic [31:0] pc, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] imm,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                 input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic rw, input logic mr, input logic mw);
        idex_t e;
        e.valid = v;      e.pc = pc;         e.rs1_data = d1;  e.rs2_data = d2;
        e.imm = imm;      e.rs1 = r1;        e.rs2 = r2;       e.rd = rd;
        e.opcode = op;    e.funct3 = f3;     e.funct7b5 = f7;
        e.regwrite = rw;  e.memread = mr;    e.memwrite = mw;
        return e;
    endfunction

    // lw x6,0(x2) with RF_OUT1=0x1000, RF_OUT2=0x2222
    function automatic idex_t lw_exp(input logic [31:0] pc);
        return mk(1'b1, pc, 32'h1000, 32'h0, 32'h0, 5'd2, 5'd0, 5'd6, 7'h03, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    endfunction

    // Monitor: one ID/EX sample per clock, compared against the oldest queued expectation.
    initial begin
        idex_t e;
        idex_t a;
        bit    c;
        string n;
        bit    bad;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                c = ctl_q.pop_front();
                n = name_q.pop_front();
                a.valid = bus.EX_VALID;        a.pc = bus.EX_PC;
                a.rs1_data = bus.EX_RS1DATA;   a.rs2_data = bus.EX_RS2DATA;
                a.imm = bus.EX_IMM;            a.rs1 = bus.EX_RS1;
                a.rs2 = bus.EX_RS2;            a.rd = bus.EX_RD;
                a.opcode = bus.EX_OPCODE;      a.funct3 = bus.EX_FUNCT3;
                a.funct7b5 = bus.EX_FUNCT7B5;  a.regwrite = bus.EX_REGWRITE;
                a.memread = bus.EX_MEMREAD;    a.memwrite = bus.EX_MEMWRITE;
                if (c)
                    bad = ({a.valid, a.regwrite, a.memread, a.memwrite} !==
                           {e.valid, e.regwrite, e.memread, e.memwrite});
                else
                    bad = (a !== e);
                tests++;
                if (bad) begin
                    errors++;
                    $display("FAIL %s idex: got %h want %h", n, a, e);
                end
            end
        end
    end

    task automatic cyc(input string name, input logic rst, input logic [31:0] instr,
                       input logic [31:0] pc, input logic v, input logic fl,
                       input logic [31:0] r1, input logic [31:0] r2, input logic ww,
                       input logic [4:0] wa, input logic [31:0] wd, input logic exp_stall,
                       input idex_t e_in, input bit ctl_only);
        logic [9:0] exp_addr;
        RESET        = rst;
        bus.IF_INSTR = instr;
        bus.IF_PC    = pc;
        bus.IF_VALID = v;
        bus.FLUSH    = fl;
        bus.RF_OUT1  = r1;
        bus.RF_OUT2  = r2;
        bus.WB_WRITE = ww;
        bus.WB_ADDR  = wa;
        bus.WB_DATA  = wd;
        exp_addr     = {instr[19:15], instr[24:20]};
        #1;
        tests++;
        if (bus.STALL !== exp_stall) begin
            errors++;
            $display("FAIL %s stall: got %b want %b", name, bus.STALL, exp_stall);
        end
        tests++;
        if ({bus.RF_OUT1ADDR, bus.RF_OUT2ADDR} !== exp_addr) begin
            errors++;
            $display("FAIL %s rfaddr: got %h want %h", name, {bus.RF_OUT1ADDR, bus.RF_OUT2ADDR}, exp_addr);
        end
        exp_q.push_back(e_in);
        ctl_q.push_back(ctl_only);
        name_q.push_back(name);
        @(posedge CLK);
        #2;
    endtask

    localparam logic [31:0] LW_X6   = 32'h0001_2303;  // lw  x6,0(x2)
    localparam logic [31:0] ADD_X7  = 32'h0013_03B3;  // add x7,x6,x1
    localparam logic [31:0] SW_X6   = 32'hFE13_2E23;  // sw  x1,-4(x6)

    initial begin
        idex_t z;
        idex_t add_ok;
        z = '0;
        tests = 0;
        errors = 0;
        RESET = 1'b1;
        bus.IF_INSTR = 32'hDEADBEEF; bus.IF_PC = 32'h0; bus.IF_VALID = 1'b1; bus.FLUSH = 1'b0;
        bus.RF_OUT1 = 32'h0; bus.RF_OUT2 = 32'h0; bus.WB_WRITE = 1'b0; bus.WB_ADDR = 5'd0; bus.WB_DATA = 32'h0;
        @(posedge CLK);
        #2;

        cyc("reset0", 1, 32'hDEADBEEF, 32'hCAFE0000, 1, 0, 32'h5555, 32'h6666, 1, 5'd3, 32'h77, 0, z, 0);
        cyc("reset1", 1, 32'hDEADBEEF, 32'hCAFE0004, 1, 0, 32'h5555, 32'h6666, 1, 5'd3, 32'h77, 0, z, 0);
        cyc("addi_m1", 0, 32'hFFF00293, 32'h100, 1, 0, 32'h55, 32'h77, 0, 5'd0, 32'h0, 0,
            mk(1, 32'h100, 32'h0, 32'h77, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd5, 7'h13, 3'd0, 1, 1, 0, 0), 0);
        cyc("bypass", 0, 32'h000180B3, 32'h104, 1, 0, 32'h11, 32'h22, 1, 5'd3, 32'hAB, 0,
            mk(1, 32'h104, 32'hAB, 32'h0, 32'h0, 5'd3, 5'd0, 5'd1, 7'h33, 3'd0, 0, 1, 0, 0), 0);
        cyc("lw_a", 0, LW_X6, 32'h108, 1, 0, 32'h1000, 32'h2222, 0, 5'd0, 32'h0, 0, lw_exp(32'h108), 0);
        cyc("add_stall", 0, ADD_X7, 32'h10C, 1, 0, 32'h66, 32'h11, 0, 5'd0, 32'h0, 1, z, 1);
        add_ok = mk(1, 32'h10C, 32'h66, 32'h11, 32'h0, 5'd6, 5'd1, 5'd7, 7'h33, 3'd0, 0, 1, 0, 0);
        cyc("add_go", 0, ADD_X7, 32'h10C, 1, 0, 32'h66, 32'h11, 0, 5'd0, 32'h0, 0, add_ok, 0);
        cyc("lw_b", 0, LW_X6, 32'h110, 1, 0, 32'h1000, 32'h2222, 0, 5'd0, 32'h0, 0, lw_exp(32'h110), 0);
        cyc("sw_stall", 0, SW_X6, 32'h114, 1, 0, 32'h2000, 32'h1234, 0, 5'd0, 32'h0, 1, z, 1);
        cyc("sw_go", 0, SW_X6, 32'h114, 1, 0, 32'h2000, 32'h1234, 0, 5'd0, 32'h0, 0,
            mk(1, 32'h114, 32'h2000, 32'h1234, 32'hFFFFFFFC, 5'd6, 5'd1, 5'd28, 7'h23, 3'd2, 1, 0, 0, 1), 0);
        cyc("lw_c", 0, LW_X6, 32'h118, 1, 0, 32'h1000, 32'h2222, 0, 5'd0, 32'h0, 0, lw_exp(32'h118), 0);
        cyc("lui_nostall", 0, 32'h00030337, 32'h11C, 1, 0, 32'h99, 32'h88, 0, 5'd0, 32'h0, 0,
            mk(1, 32'h11C, 32'h99, 32'h0, 32'h00030000, 5'd6, 5'd0, 5'd6, 7'h37, 3'd0, 0, 1, 0, 0), 0);
        // beq x0,x0,-4
        cyc("beq_imm", 0, 32'hFE000EE3, 32'h120, 1, 0, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0,
            mk(1, 32'h120, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd29, 7'h63, 3'd0, 1, 0, 0, 0), 0);
        cyc("jal_2048", 0, 32'h001000EF, 32'h124, 1, 0, 32'h41, 32'h42, 0, 5'd0, 32'h0, 0,
            mk(1, 32'h124, 32'h0, 32'h42, 32'h00000800, 5'd0, 5'd1, 5'd1, 7'h6F, 3'd0, 0, 1, 0, 0), 0);
        cyc("lw_d", 0, LW_X6, 32'h128, 1, 0, 32'h1000, 32'h2222, 0, 5'd0, 32'h0, 0, lw_exp(32'h128), 0);
        cyc("flush_hz", 0, ADD_X7, 32'h12C, 1, 1, 32'h66, 32'h11, 0, 5'd0, 32'h0, 0, z, 1);
        cyc("add_x0", 0, 32'h00208033, 32'h130, 1, 0, 32'h10, 32'h20, 0, 5'd0, 32'h0, 0,
            mk(1, 32'h130, 32'h10, 32'h20, 32'h0, 5'd1, 5'd2, 5'd0, 7'h33, 3'd0, 0, 0, 0, 0), 0);
        cyc("lw_e", 0, LW_X6, 32'h134, 1, 0, 32'h1000, 32'h2222, 0, 5'd0, 32'h0, 0, lw_exp(32'h134), 0);
        cyc("reset_stall", 1, ADD_X7, 32'h138, 1, 0, 32'h66, 32'h11, 0, 5'd0, 32'h0, 1, z, 0);
        add_ok.pc = 32'h138;
        cyc("after_reset", 0, ADD_X7, 32'h138, 1, 0, 32'h66, 32'h11, 0, 5'd0, 32'h0, 0, add_ok, 0);
        cyc("lw_invalid", 0, LW_X6, 32'h13C, 0, 0, 32'h1000, 32'h2222, 0, 5'd0, 32'h0, 0, z, 1);
        add_ok.pc = 32'h140;
        cyc("add_no_hz", 0, ADD_X7, 32'h140, 1, 0, 32'h66, 32'h11, 0, 5'd0, 32'h0, 0, add_ok, 0);
        cyc("nop", 0, 32'h00000013, 32'h144, 1, 0, 32'h3, 32'h4, 0, 5'd0, 32'h0, 0,
            mk(1, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 7'h0, 3'd0, 0, 0, 0, 0), 1);

        @(posedge CLK);
        #3;
        tests++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
